// File: rtl/sysarray_pkg.sv
// rtl/sysarray_pkg.sv - shared constants and types for the systolic array drain
//
// Purpose: element width, array dimension, index widths and the drain FSM
// state type used by sysarray8_drain and its result buffer.
// Ports: none (package).
package sysarray_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int IDX_W  = 3;   // row / column index width
  localparam int CNT_W  = 6;   // flat element index width (64 elements)

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/sysarray8_drain_buf.sv
// rtl/sysarray8_drain_buf.sv - 8x8 result buffer, one column write, one random read
//
// Purpose: holds one captured result frame. A whole column (one word per
// row) is written per cycle; any single element is read combinationally.
// Ports:
//   clk      - write clock
//   wr_en    - write the column selected by wr_col
//   wr_col   - column address of the write
//   wr_data  - one word per row, wr_data[i] goes to row i
//   rd_row   - read row address
//   rd_col   - read column address
//   rd_data  - element at [rd_row][rd_col]
module sysarray8_drain_buf #(
  parameter int DATA_W = sysarray_pkg::DATA_W,
  parameter int N      = sysarray_pkg::N
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [sysarray_pkg::IDX_W-1:0]      wr_col,
  input  logic [N-1:0][DATA_W-1:0]            wr_data,
  input  logic [sysarray_pkg::IDX_W-1:0]      rd_row,
  input  logic [sysarray_pkg::IDX_W-1:0]      rd_col,
  output logic [DATA_W-1:0]                   rd_data
);

  logic [N-1:0][DATA_W-1:0] row_rd;

  // Storage is split per row so each row has exactly one writing process.
  // Contents are intentionally not reset.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [DATA_W-1:0] cells [N];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        cells[wr_col] <= wr_data[i];
      end
    end

    assign row_rd[i] = cells[rd_col];
  end

  assign rd_data = row_rd[rd_row];

endmodule

// File: rtl/sysarray8_drain.sv
// rtl/sysarray8_drain.sv - captures an 8x8 result frame from the east ports and streams it out
//
// Purpose: after the array pulses okay, eight columns of results arrive on
// east0..east7 (column 7 first). They are captured into a local buffer and
// then streamed one element per valid/ready beat with row/column tags.
// Build option: define SYSARRAY_DRAIN_TRANSPOSE_EN for column-major stream
// order; default is row-major.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   okay             - array done pulse, starts a frame
//   east0..east7     - row i result port
//   m_valid/m_ready  - output handshake
//   m_data           - element value
//   m_row, m_col     - true indices of m_data
//   m_last           - final element of the frame (C[7][7])
//   busy             - capturing or streaming
//   overflow         - sticky: a frame start was dropped
module sysarray8_drain #(
  parameter int DATA_W = sysarray_pkg::DATA_W,
  parameter int N      = sysarray_pkg::N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              okay,
  input  logic [DATA_W-1:0] east0,
  input  logic [DATA_W-1:0] east1,
  input  logic [DATA_W-1:0] east2,
  input  logic [DATA_W-1:0] east3,
  input  logic [DATA_W-1:0] east4,
  input  logic [DATA_W-1:0] east5,
  input  logic [DATA_W-1:0] east6,
  input  logic [DATA_W-1:0] east7,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        m_row,
  output logic [2:0]        m_col,
  output logic              m_last,
  output logic              busy,
  output logic              overflow
);

  import sysarray_pkg::*;

  drain_state_t             state, state_next;
  logic [IDX_W-1:0]         cap_cnt, cap_cnt_next;
  logic [CNT_W-1:0]         out_idx, out_idx_next;
  logic                     overflow_next;

  logic                     wr_en;
  logic [IDX_W-1:0]         wr_col;
  logic [N-1:0][DATA_W-1:0] east;
  logic [IDX_W-1:0]         rd_row, rd_col;
  logic [DATA_W-1:0]        rd_data;

  assign east = {east7, east6, east5, east4, east3, east2, east1, east0};

  // Stream order only changes how out_idx maps onto the buffer; the tags
  // reported on m_row/m_col are always the true element position.
`ifdef SYSARRAY_DRAIN_TRANSPOSE_EN
  assign rd_col = out_idx[5:3];
  assign rd_row = out_idx[2:0];
`else
  assign rd_row = out_idx[5:3];
  assign rd_col = out_idx[2:0];
`endif

  sysarray8_drain_buf #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_data (east),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_cnt  <= '0;
      out_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cap_cnt  <= cap_cnt_next;
      out_idx  <= out_idx_next;
      overflow <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state;
    cap_cnt_next  = cap_cnt;
    out_idx_next  = out_idx;
    overflow_next = overflow;
    wr_en         = 1'b0;
    wr_col        = '0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    m_data        = '0;
    m_row         = '0;
    m_col         = '0;
    busy          = 1'b0;

    case (state)
      IDLE: begin
        if (okay) begin
          // Frame cycle 0 carries column 7.
          wr_en        = 1'b1;
          wr_col       = IDX_W'(N - 1);
          cap_cnt_next = IDX_W'(1);
          state_next   = CAPTURE;
        end
      end

      CAPTURE: begin
        busy         = 1'b1;
        wr_en        = 1'b1;
        wr_col       = IDX_W'(N - 1) - cap_cnt;
        cap_cnt_next = cap_cnt + IDX_W'(1);
        // A start while a frame is still arriving cannot be honoured.
        if (okay && (cap_cnt != '0)) begin
          overflow_next = 1'b1;
        end
        if (cap_cnt == IDX_W'(N - 1)) begin
          cap_cnt_next = '0;
          out_idx_next = '0;
          state_next   = STREAM;
        end
      end

      STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = (out_idx == '1);
        m_data  = rd_data;
        m_row   = rd_row;
        m_col   = rd_col;
        // Includes okay coinciding with the final handshake: no restart.
        if (okay) begin
          overflow_next = 1'b1;
        end
        if (m_ready) begin
          out_idx_next = out_idx + CNT_W'(1);
          if (out_idx == '1) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sysarray8_drain.sv
// tb/tb_sysarray8_drain.sv - self-checking bench for sysarray8_drain
module tb_sysarray8_drain;

  logic        clk;
  logic        rst_n;
  logic        okay;
  logic [31:0] east_v [8];
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  m_row;
  logic [2:0]  m_col;
  logic        m_last;
  logic        busy;
  logic        overflow;

  sysarray8_drain dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .okay     (okay),
    .east0    (east_v[0]),
    .east1    (east_v[1]),
    .east2    (east_v[2]),
    .east3    (east_v[3]),
    .east4    (east_v[4]),
    .east5    (east_v[5]),
    .east6    (east_v[6]),
    .east7    (east_v[7]),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } beat_t;

  typedef struct {
    int base;
    bit rnd;
    int inject;
    bit exp_ovf;
  } frame_t;

  beat_t  exp_q [$];
  frame_t tbl [5];

  int total = 0;
  int bad   = 0;
  int beats = 0;
  int cyc   = 0;
  int last_hs_edge = 0;
  bit rnd_ready = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready driver: always ready, or a pseudo-random toggle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each accepted beat against the scoreboard and checks
  // that stalled outputs hold steady.
  initial begin
    bit          hold;
    logic [31:0] h_data;
    logic [2:0]  h_row, h_col;
    logic        h_last;
    beat_t       e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          total++;
          if (m_valid !== 1'b1 || m_data !== h_data || m_row !== h_row ||
              m_col !== h_col || m_last !== h_last) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b d=%0d r=%0d c=%0d l=%0b expected v=1 d=%0d r=%0d c=%0d l=%0b",
                     m_valid, m_data, m_row, m_col, m_last, h_data, h_row, h_col, h_last);
          end
        end
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_beat: got d=%0d expected no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e.data || m_row !== e.row || m_col !== e.col || m_last !== e.last) begin
              bad++;
              $display("FAIL beat: got d=%0d r=%0d c=%0d l=%0b expected d=%0d r=%0d c=%0d l=%0b",
                       m_data, m_row, m_col, m_last, e.data, e.row, e.col, e.last);
            end
          end
          beats++;
          last_hs_edge = cyc + 1;
        end
        hold   = m_valid && !m_ready;
        h_data = m_data;
        h_row  = m_row;
        h_col  = m_col;
        h_last = m_last;
      end
    end
  end

  // Pushes the expected beats and drives the eight capture cycles.
  // Called #1 after a rising edge; c_ok is the edge that samples okay.
  task automatic start_frame(input int base, output int c_ok);
    beat_t b;
    int r, c;
    for (int idx = 0; idx < 64; idx++) begin
`ifdef SYSARRAY_DRAIN_TRANSPOSE_EN
      c = idx / 8;
      r = idx % 8;
`else
      r = idx / 8;
      c = idx % 8;
`endif
      b.data = 32'(base + 100 * r + c);
      b.row  = 3'(r);
      b.col  = 3'(c);
      b.last = (idx == 63);
      exp_q.push_back(b);
    end
    chk("busy_idle_before_okay", 64'(busy), 64'd0);
    c_ok = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      okay = (k == 0);
      for (int i = 0; i < 8; i++) east_v[i] = 32'(base + 100 * i + (7 - k));
      @(posedge clk);
      #1;
      if (k == 0) chk("busy_after_okay", 64'(busy), 64'd1);
    end
    okay = 1'b0;
    for (int i = 0; i < 8; i++) east_v[i] = 32'hdead_0000;
  endtask

  task automatic wait_beats(input int target);
    int g = 0;
    while (beats < target && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("beat_count_reached", 64'(beats >= target), 64'd1);
  endtask

  initial begin
    int c_ok, start;

    tbl[0] = '{base: 0,    rnd: 0, inject: -1, exp_ovf: 0};
    tbl[1] = '{base: 1000, rnd: 1, inject: -1, exp_ovf: 0};
    tbl[2] = '{base: 2000, rnd: 0, inject: -1, exp_ovf: 0};
    tbl[3] = '{base: 3000, rnd: 1, inject: 20, exp_ovf: 1};
    tbl[4] = '{base: 4000, rnd: 0, inject: -1, exp_ovf: 1};

    rst_n = 1'b0;
    okay  = 1'b0;
    for (int i = 0; i < 8; i++) east_v[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid",  64'(m_valid),  64'd0);
    chk("reset_m_last",   64'(m_last),   64'd0);
    chk("reset_busy",     64'(busy),     64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_m_data",   64'(m_data),   64'd0);
    chk("reset_m_rowcol", 64'({m_row, m_col}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frames run back to back: each okay is sampled one cycle after the
    // previous frame's final handshake.
    for (int f = 0; f < 5; f++) begin
      rnd_ready = tbl[f].rnd;
      start = beats;
      start_frame(tbl[f].base, c_ok);
      wait_beats(start + 1);
      if (!tbl[f].rnd) chk("first_beat_edge", 64'(last_hs_edge - c_ok), 64'd8);
      if (tbl[f].inject >= 0) begin
        wait_beats(start + tbl[f].inject);
        okay = 1'b1;
        for (int i = 0; i < 8; i++) east_v[i] = 32'hbad0_0000;
        @(posedge clk);
        #1;
        okay = 1'b0;
      end
      wait_beats(start + 64);
      if (!tbl[f].rnd) chk("last_beat_edge", 64'(last_hs_edge - c_ok), 64'd71);
      chk("m_valid_after_frame",  64'(m_valid),  64'd0);
      chk("busy_after_frame",     64'(busy),     64'd0);
      chk("overflow_after_frame", 64'(overflow), 64'(tbl[f].exp_ovf));
      chk("scoreboard_drained",   64'(exp_q.size()), 64'd0);
    end

    // Reset at beat 30 of a frame, then a fresh frame.
    rnd_ready = 0;
    start = beats;
    start_frame(5000, c_ok);
    wait_beats(start + 30);
    rst_n = 1'b0;
    #1;
    chk("midreset_m_valid",  64'(m_valid),  64'd0);
    chk("midreset_busy",     64'(busy),     64'd0);
    chk("midreset_overflow", 64'(overflow), 64'd0);
    chk("midreset_m_data",   64'(m_data),   64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = beats;
    start_frame(6000, c_ok);
    wait_beats(start + 1);
    chk("post_reset_first_edge", 64'(last_hs_edge - c_ok), 64'd8);
    wait_beats(start + 64);
    chk("post_reset_busy",     64'(busy),     64'd0);
    chk("post_reset_overflow", 64'(overflow), 64'd0);
    chk("post_reset_drained",  64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
